// File: rtl/serdes_link_arbiter.sv
// Round-robin arbiter that shares one serdes parallel input among NUM_REQ requesters.
// A grant is held for up to BURST_LEN beats, then priority rotates past the owner.
module serdes_link_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          enable_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         link_data_o,
    output logic                          link_valid_o,
    input  logic                          link_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          busy_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_owner;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
    logic [ID_W-1:0]       w_pick;
    logic                  w_found;
    int                    w_idx;
    logic                  w_grant;
    logic                  w_owner_valid;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_release;
    logic [ID_W-1:0]       w_next_ptr;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_data[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (!w_found && req_valid_i[ID_W'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = ID_W'(w_idx);
            end
        end
    end

    assign w_grant       = (r_state == ST_GRANT);
    assign w_owner_valid = req_valid_i[r_owner];
    assign w_xfer        = w_grant && w_owner_valid && link_ready_i;
    assign w_last        = (r_beat_cnt == CNT_W'(BURST_LEN - 1));
    // An owner that drops valid gives up the rest of its burst.
    assign w_release     = w_grant && ((w_xfer && w_last) || !w_owner_valid);
    assign w_next_ptr    = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        link_valid_o = 1'b0;
        link_data_o  = '0;
        req_ready_o  = '0;
        grant_id_o   = '0;
        busy_o       = 1'b0;
        if (w_grant) begin
            link_valid_o         = w_owner_valid;
            link_data_o          = w_req_data[r_owner];
            req_ready_o[r_owner] = link_ready_i;
            grant_id_o           = r_owner;
            busy_o               = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable_i && w_found) begin
                        r_owner    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_rr_ptr   <= w_next_ptr;
                        r_beat_cnt <= '0;
                        r_state    <= ST_IDLE;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_link_arbiter.sv
// Directed bench for serdes_link_arbiter: reset, single grant, rotation, abandon, stall,
// enable gating and mid-burst reset, with hand-derived expectations.
module tb_serdes_link_arbiter;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  link_data;
    logic        link_valid;
    logic        link_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  d [4];

    int n_checks = 0;
    int n_errors = 0;

    assign req_data = {d[3], d[2], d[1], d[0]};

    serdes_link_arbiter #(
        .DATA_WIDTH(8),
        .NUM_REQ   (4),
        .BURST_LEN (4)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .enable_i    (enable),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .link_data_o (link_data),
        .link_valid_o(link_valid),
        .link_ready_i(link_ready),
        .grant_id_o  (grant_id),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        enable     = 1'b1;
        link_ready = 1'b1;
        d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'h7E; d[3] = 8'hC1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #12;
        n_checks++;
        if (link_valid !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 ||
            link_data !== 8'h00 || grant_id !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b ready=%b busy=%b data=%h id=%0d, need all zero",
                     link_valid, req_ready, busy, link_data, grant_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (link_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_latency: link_valid=%b need 0", link_valid);
        end
        @(negedge clk); #1;
        n_checks++;
        if (link_valid !== 1'b1 || link_data !== 8'hA5 || grant_id !== 2'd0 ||
            req_ready !== 4'b0001 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_grant: valid=%b data=%h id=%0d ready=%b busy=%b need 1 a5 0 0001 1",
                     link_valid, link_data, grant_id, req_ready, busy);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_checks++;
        if (busy !== 1'b1 || link_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_drop: busy=%b valid=%b need 1 0", busy, link_valid);
        end
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_release: busy=%b need 0", busy);
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        apply_reset();
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        for (int s = 0; s < 25; s++) begin
            if (s > 0) begin
                @(negedge clk); #1;
            end
            n_checks++;
            if (s % 5 == 0) begin
                if (busy !== 1'b0 || link_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rr_bubble s=%0d: busy=%b valid=%b need 0 0", s, busy, link_valid);
                end
            end else begin
                exp_id = 2'((s / 5) % 4);
                if (busy !== 1'b1 || grant_id !== exp_id || link_data !== d[exp_id] ||
                    req_ready !== (4'b0001 << exp_id)) begin
                    n_errors++;
                    $display("FAIL rr_grant s=%0d: busy=%b id=%0d data=%h ready=%b need id=%0d data=%h",
                             s, busy, grant_id, link_data, req_ready, exp_id, d[exp_id]);
                end
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_abandon();
        apply_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
            n_errors++;
            $display("FAIL abandon_grant2: busy=%b id=%0d need 1 2", busy, grant_id);
        end
        req_valid = 4'b1101;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (busy !== 1'b1 || grant_id !== 2'd2) begin
                n_errors++;
                $display("FAIL abandon_hold i=%0d: busy=%b id=%0d need 1 2", i, busy, grant_id);
            end
        end
        req_valid = 4'b1001;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abandon_release: busy=%b need 0", busy);
        end
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 2'd3) begin
            n_errors++;
            $display("FAIL abandon_next: busy=%b id=%0d need 1 3", busy, grant_id);
        end
        $display("test_abandon done");
    endtask

    task automatic test_stall();
        apply_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        d[1]      = 8'h40;
        #1;
        @(negedge clk); #1;
        @(negedge clk);
        link_ready = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || req_ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL stall_enter: busy=%b id=%0d ready=%b need 1 1 0000", busy, grant_id, req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d[1] = 8'(8'h41 + i);
            #1;
            n_checks++;
            if (busy !== 1'b1 || grant_id !== 2'd1 || link_valid !== 1'b1 ||
                req_ready !== 4'b0000 || link_data !== 8'(8'h41 + i)) begin
                n_errors++;
                $display("FAIL stall_hold i=%0d: busy=%b id=%0d valid=%b ready=%b data=%h need 1 1 1 0000 %h",
                         i, busy, grant_id, link_valid, req_ready, link_data, 8'(8'h41 + i));
            end
        end
        link_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_errors++;
            $display("FAIL stall_resume_ready: ready=%b need 0010", req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (busy !== (i < 2)) begin
                n_errors++;
                $display("FAIL stall_complete i=%0d: busy=%b need %b", i, busy, (i < 2));
            end
        end
        $display("test_stall done");
    endtask

    task automatic test_enable();
        apply_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        @(negedge clk); #1;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (busy !== (i < 3)) begin
                n_errors++;
                $display("FAIL enable_burst i=%0d: busy=%b need %b", i, busy, (i < 3));
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (busy !== 1'b0 || link_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL enable_hold i=%0d: busy=%b valid=%b need 0 0", i, busy, link_valid);
            end
        end
        enable = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            n_errors++;
            $display("FAIL enable_regrant: busy=%b id=%0d need 1 0", busy, grant_id);
        end
        $display("test_enable done");
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            n_errors++;
            $display("FAIL midrst_pre: busy=%b id=%0d need 1 1", busy, grant_id);
        end
        @(negedge clk); #1;
        n_checks++;
        if (req_ready !== 4'b0010 || link_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_active: ready=%b valid=%b need 0010 1", req_ready, link_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (link_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || link_data !== 8'h00) begin
            n_errors++;
            $display("FAIL midrst_immediate: valid=%b ready=%b busy=%b data=%h need 0 0000 0 00",
                     link_valid, req_ready, busy, link_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            n_errors++;
            $display("FAIL midrst_regrant: busy=%b id=%0d need 1 0", busy, grant_id);
        end
        $display("test_reset_mid_burst done");
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        req_valid  = 4'b0000;
        link_ready = 1'b1;
        d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'h7E; d[3] = 8'hC1;
        test_reset();
        test_single();
        test_round_robin();
        test_abandon();
        test_stall();
        test_enable();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
